// File: rtl/uart_hex_streamer.sv
// Pops TRNG FIFO words and streams them as ASCII hex lines through a uart_tx byte handshake.
// Build option: define HEX_PREFIX_EN to send "0x" in front of every word.
module uart_hex_streamer #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned BURST_LEN = 4,
    parameter logic [7:0]  SEP_CHAR  = 8'h20,
    parameter bit          UPPER_HEX = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic              continuous,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [WORD_W-1:0] fifo_rd_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              active,
    output logic              underrun,
    output logic [15:0]       words_sent
);

    localparam int unsigned Nibbles = WORD_W / 4;
    localparam int unsigned NibW    = (Nibbles > 1) ? $clog2(Nibbles) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StPop,
        StCapture,
        StChar,
        StWaitHi,
        StWaitLo,
        StNext,
        StSep,
        StCr,
        StLf
`ifdef HEX_PREFIX_EN
        ,
        StPfx0,
        StPfx1
`endif
    } state_e;

    state_e            state_q;
    state_e            kind_q;  // which byte is in flight, decides where WAIT_LO resumes
    logic [WORD_W-1:0] word_q;
    logic [NibW-1:0]   nib_idx_q;
    logic [7:0]        burst_cnt_q;
    logic [3:0]        cur_nib;

    assign cur_nib = word_q[{nib_idx_q, 2'b00} +: 4];

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n})
                           : ((UPPER_HEX ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            kind_q      <= StIdle;
            word_q      <= '0;
            nib_idx_q   <= '0;
            burst_cnt_q <= '0;
            fifo_rd_en  <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            active      <= 1'b0;
            underrun    <= 1'b0;
            words_sent  <= '0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_start   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if ((trigger | continuous) && !fifo_empty) begin
                        fifo_rd_en  <= 1'b1;
                        active      <= 1'b1;
                        underrun    <= 1'b0;
                        burst_cnt_q <= '0;
                        state_q     <= StPop;
                    end
                end
                StPop: state_q <= StCapture;
                StCapture: begin
                    word_q    <= fifo_rd_data;
                    nib_idx_q <= NibW'(Nibbles - 1);
`ifdef HEX_PREFIX_EN
                    state_q   <= StPfx0;
`else
                    state_q   <= StChar;
`endif
                end
`ifdef HEX_PREFIX_EN
                StPfx0: begin
                    tx_data  <= 8'h30;
                    tx_start <= 1'b1;
                    kind_q   <= StPfx0;
                    state_q  <= StWaitHi;
                end
                StPfx1: begin
                    tx_data  <= 8'h78;
                    tx_start <= 1'b1;
                    kind_q   <= StPfx1;
                    state_q  <= StWaitHi;
                end
`endif
                StChar: begin
                    tx_data  <= hex_char(cur_nib);
                    tx_start <= 1'b1;
                    kind_q   <= StChar;
                    state_q  <= StWaitHi;
                end
                StWaitHi: if (tx_busy) state_q <= StWaitLo;
                StWaitLo: begin
                    if (!tx_busy) begin
                        case (kind_q)
                            StChar: begin
                                if (nib_idx_q == '0) begin
                                    words_sent  <= words_sent + 16'd1;
                                    burst_cnt_q <= burst_cnt_q + 8'd1;
                                    state_q     <= StNext;
                                end else begin
                                    nib_idx_q <= nib_idx_q - 1'b1;
                                    state_q   <= StChar;
                                end
                            end
                            StSep: begin
                                // Defensive: never pop an empty FIFO
                                if (fifo_empty) begin
                                    underrun <= 1'b1;
                                    state_q  <= StCr;
                                end else begin
                                    fifo_rd_en <= 1'b1;
                                    state_q    <= StPop;
                                end
                            end
                            StCr: state_q <= StLf;
                            StLf: begin
                                if (continuous && !fifo_empty) begin
                                    fifo_rd_en  <= 1'b1;
                                    burst_cnt_q <= '0;
                                    state_q     <= StPop;
                                end else begin
                                    active  <= 1'b0;
                                    state_q <= StIdle;
                                end
                            end
`ifdef HEX_PREFIX_EN
                            StPfx0: state_q <= StPfx1;
                            StPfx1: state_q <= StChar;
`endif
                            default: begin
                                active  <= 1'b0;
                                state_q <= StIdle;
                            end
                        endcase
                    end
                end
                StNext: begin
                    if (burst_cnt_q == 8'(BURST_LEN)) begin
                        state_q <= StCr;
                    end else if (fifo_empty) begin
                        underrun <= 1'b1;
                        state_q  <= StCr;
                    end else begin
                        state_q <= StSep;
                    end
                end
                StSep: begin
                    tx_data  <= SEP_CHAR;
                    tx_start <= 1'b1;
                    kind_q   <= StSep;
                    state_q  <= StWaitHi;
                end
                StCr: begin
                    tx_data  <= 8'h0D;
                    tx_start <= 1'b1;
                    kind_q   <= StCr;
                    state_q  <= StWaitHi;
                end
                StLf: begin
                    tx_data  <= 8'h0A;
                    tx_start <= 1'b1;
                    kind_q   <= StLf;
                    state_q  <= StWaitHi;
                end
                default: begin
                    active  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
